// File: rtl/sha256_compress_if.sv
// Block/chaining-value handshake between the padding front end and the SHA-256 compression engine.
interface sha256_compress_if;
  logic         start;
  logic         ready;
  logic [511:0] block;
  logic [255:0] h_in;
  logic         done;
  logic [255:0] h_out;

  modport master (output start, block, h_in, input ready, done, h_out);
  modport slave  (input start, block, h_in, output ready, done, h_out);
endinterface

// File: rtl/sha256_compress.sv
// Iterative SHA-256 compression: one round per clock, rolling 16-word message schedule,
// K constants fetched from an external combinational ROM addressed by the round counter.
module sha256_compress #(
  parameter int ROUNDS = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  sha256_compress_if.slave bus,
  output logic [5:0]       k_addr,
  input  logic [31:0]      k
);

  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_FINAL = 2'd2
  } state_e;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  state_e        state_q, state_d;
  logic [5:0]    round_q, round_d;
  logic [31:0]   w_q     [16];
  logic [31:0]   w_d     [16];
  logic [31:0]   v_q     [8];
  logic [31:0]   v_d     [8];
  logic [31:0]   hsave_q [8];
  logic [31:0]   hsave_d [8];
  logic [255:0]  h_out_q, h_out_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic [31:0]   t1_s, t2_s, w_new_s;

  // Round datapath, schedule expansion and next-state selection.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    w_d     = w_q;
    v_d     = v_q;
    hsave_d = hsave_q;
    h_out_d = h_out_q;
    ready_d = ready_q;
    done_d  = 1'b0;

    // v_q[0..7] hold the working variables a..h
    t1_s    = v_q[7] + big_sigma1(v_q[4]) + ch(v_q[4], v_q[5], v_q[6]) + k + w_q[0];
    t2_s    = big_sigma0(v_q[0]) + maj(v_q[0], v_q[1], v_q[2]);
    w_new_s = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          for (int i = 0; i < 16; i++) begin
            w_d[i] = bus.block[511 - 32*i -: 32];
          end
          for (int i = 0; i < 8; i++) begin
            hsave_d[i] = bus.h_in[255 - 32*i -: 32];
            v_d[i]     = bus.h_in[255 - 32*i -: 32];
          end
          round_d = 6'd0;
          ready_d = 1'b0;
          state_d = S_ROUND;
        end else begin
          ready_d = 1'b1;
        end
      end
      S_ROUND: begin
        v_d[0] = t1_s + t2_s;
        v_d[1] = v_q[0];
        v_d[2] = v_q[1];
        v_d[3] = v_q[2];
        v_d[4] = v_q[3] + t1_s;
        v_d[5] = v_q[4];
        v_d[6] = v_q[5];
        v_d[7] = v_q[6];
        for (int i = 0; i < 15; i++) begin
          w_d[i] = w_q[i + 1];
        end
        w_d[15] = w_new_s;
        if (round_q == LAST_ROUND) begin
          round_d = 6'd0;
          state_d = S_FINAL;
        end else begin
          round_d = round_q + 6'd1;
        end
      end
      S_FINAL: begin
        for (int i = 0; i < 8; i++) begin
          h_out_d[255 - 32*i -: 32] = hsave_q[i] + v_q[i];
        end
        done_d  = 1'b1;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        round_d = 6'd0;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      round_q <= 6'd0;
      h_out_q <= 256'd0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= 32'd0;
      end
      for (int i = 0; i < 8; i++) begin
        v_q[i]     <= 32'd0;
        hsave_q[i] <= 32'd0;
      end
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      h_out_q <= h_out_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= w_d[i];
      end
      for (int i = 0; i < 8; i++) begin
        v_q[i]     <= v_d[i];
        hsave_q[i] <= hsave_d[i];
      end
    end
  end

  // The counter is already zero outside ROUND, so it doubles as the ROM address.
  assign k_addr    = round_q;
  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.h_out = h_out_q;

endmodule

// File: doc/sha256_compress.md
Name: sha256_compress

Overview:
Iterative SHA-256 compression engine, one round per clock. It consumes one padded 512-bit message block plus a 256-bit chaining value and produces the updated 256-bit chaining value. It drives the round index to the K-constant ROM (6-bit address in, 32-bit constant out, purely combinational) and consumes the returned constant in the same cycle. It sits between the block-padding front end and the digest output register.

Parameters:
ROUNDS, 64, number of compression rounds; fixed by SHA-256 and not to be overridden except in debug builds.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only while ready=1
ready  output  1  engine idle and able to accept start
block  input  512  message block; block[511:480]=W0 … block[31:0]=W15
h_in  input  256  chaining value; h_in[255:224]=H0 … h_in[31:0]=H7
k_addr  output  6  round index to the constant ROM
k  input  32  K[k_addr] from the ROM, combinational
done  output  1  one-cycle pulse when h_out is updated
h_out  output  256  resulting chaining value, same packing as h_in; held until the next done

Behaviour:
- Reset (rst_n low, async): state=IDLE, ready=1, done=0, k_addr=0, h_out=0, round counter=0, working regs a..h=0, schedule window=0.
- States: IDLE, ROUND, FINAL.
- IDLE:
  - ready=1.
  - On start=1 at a clock edge: latch block into the 16-word window w[0..15] (w[0]=W0), latch h_in into hsave[0..7] and into a..h, round=0, go to ROUND.
  - start is ignored outside IDLE.
  - block and h_in are sampled only at accept; they may change afterwards.
- ROUND:
  - ready=0. k_addr=round (registered, equal to the counter). Wt=w[0].
  - T1=h+Σ1(e)+Ch(e,f,g)+k+Wt and T2=Σ0(a)+Maj(a,b,c), all mod 2^32.
    - Σ0=ROTR2^ROTR13^ROTR22, Σ1=ROTR6^ROTR11^ROTR25.
    - σ0=ROTR7^ROTR18^SHR3, σ1=ROTR17^ROTR19^SHR10.
  - Update: h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2.
  - Schedule: shift the window down one word (w[i]←w[i+1]); w[15]←σ1(w[14])+w[9]+σ0(w[1])+w[0]. Compute every cycle; words produced in the last 16 rounds are unused.
  - round increments each cycle. When round==ROUNDS-1, the update completes and the state goes to FINAL; round wraps to 0.
- FINAL (one cycle):
  - h_out[i]←hsave[i]+{a..h}[i] mod 2^32.
  - done=1 on the following cycle, coincident with the new h_out.
  - Return to IDLE with ready=1 in that same cycle.
- Latency: start accepted at edge 0 → rounds on edges 1..64 → FINAL edge 65 → done=1 and h_out valid during cycle 65–66.
- Throughput: one block per 66 cycles. A new start may be accepted on the cycle where done=1, because ready=1 then.
- Back-to-back chaining: the upstream may feed h_out directly into h_in on the same cycle that done=1.
- Reset mid-operation: abort immediately to reset values. No done is produced, and h_out clears to 0.
- k_addr is only meaningful in ROUND. It holds 0 elsewhere.
- All arithmetic is unsigned 32-bit with carry discarded.

Test Plan:
- Reset values: hold rst_n=0 and pulse start → ready=1, done=0, h_out=0, k_addr=0. Release rst_n → no done for 100 cycles.
- "abc" vector:
  - Stimulus: block={61626380, 13×00000000, 00000000, 00000018}, h_in=IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19).
  - Response: done exactly 66 cycles after the start edge. h_out=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
  - k_addr steps 0..63 on consecutive cycles.
- Empty message:
  - Stimulus: block={80000000, 15×00000000}, h_in=IV.
  - Response: h_out=e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block chaining:
  - Stimulus: 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq". Issue the second start on the done cycle with h_in=h_out.
  - Response: final h_out=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Busy rejection and sampling:
  - Stimulus: assert start with garbage block/h_in during ROUND, and change block after accept.
  - Response: the "abc" digest is unchanged and exactly one done pulse occurs.
- Async abort: drop rst_n at round 30 → outputs reset without waiting for a clock edge. A subsequent "abc" run yields the correct digest.
